alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised, handshaked execute unit for the datapath's next generation. It combines ALUOp/funct decoding with a registered ALU and an iterative multiplier (optionally also a divider) that writes HI/LO. It sits in the EX stage and replaces the combinational ALU-control path. Single-cycle ops complete one cycle after acceptance; multiply and divide stall the front end through `in_ready`.

## Interface
- `WIDTH`, default 32: operand, result, HI and LO width; must be ≥ 4.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: operation request.
- `in_ready` output, 1 bit: `(state == IDLE)`; a transfer occurs on an edge where `in_valid & in_ready`.
- `alu_op` input, 2 bits: 00 add, 01 sub, 10 decode `funct`, 11 illegal.
- `funct` input, 6 bits: R-type function field.
- `a`, `b` input, `WIDTH` bits: operands, sampled at acceptance only.
- `out_valid` output, 1 bit: one-cycle pulse per completed operation; no backpressure.
- `result` output, `WIDTH` bits: registered result. For mult/div it equals the new LO.
- `zero` output, 1 bit: registered `(result == 0)` for the pulse.
- `err` output, 1 bit: registered illegal-op or divide-by-zero flag, valid with `out_valid`.
- `hi`, `lo` output, `WIDTH` bits each: architectural HI/LO registers.

## Operation
- States:
  - IDLE.
  - MUL: iterative shift-add, `WIDTH` iterations.
  - DIV: restoring divide, `WIDTH` iterations; only exists with the macro below.
- Single-cycle ops, accepted in IDLE; the state stays IDLE:
  - `alu_op` 00 → a+b; 01 → a−b.
  - `alu_op` 10 with funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 1/0), 0x2B sltu.
  - funct 0x10 mfhi → result = hi; 0x12 mflo → result = lo.
  - Add and sub wrap modulo 2^WIDTH. There is no overflow trap.
- Multiply ops:
  - funct 0x18 mult (signed) and 0x19 multu (unsigned).
  - IDLE→MUL on acceptance; an iteration counter is loaded with `WIDTH`.
  - MUL→IDLE when the counter reaches 0.
  - {hi,lo} = full 2·WIDTH-bit product.
- Illegal ops:
  - Covers `alu_op` 11 and any unlisted funct, including div/divu when the macro is off.
  - Completes in one cycle with result 0 and err=1. HI/LO are unchanged.
- Only mult/div write HI/LO. No other op modifies them.
- `a`, `b`, `alu_op` and `funct` are ignored when no transfer occurs.

## Timing
- Reset: at any edge with `reset`=1 the block is forced to:
  - state IDLE, counter 0;
  - `out_valid`=0, `result`=0, `zero`=0, `err`=0;
  - `hi`=0, `lo`=0.
- Reset mid-MUL/DIV aborts the operation. No `out_valid` is produced and HI/LO read 0.
- Inputs are ignored on reset edges. `in_ready` is 1 in the cycle after reset.
- Single-cycle op accepted at edge k:
  - `out_valid`, `result`, `zero` and `err` are valid in cycle k+1.
  - `in_ready` stays 1, so throughput is one op per cycle.
- Mult/div accepted at edge k:
  - `in_ready`=0 from cycle k+1 through cycle k+WIDTH.
  - At edge k+WIDTH, HI, LO, `result`, `zero` and `err` are updated and `out_valid` is set.
  - `in_ready` returns to 1 in the same cycle, so total latency is WIDTH cycles.
- An mfhi/mflo accepted in the `out_valid` cycle of a mult returns the new HI/LO.
- `out_valid` is 0 in every cycle that does not follow a completion edge.

## Configuration
- `ALU_DIV_EN` defined:
  - Adds the DIV state.
  - funct 0x1A div (signed) and 0x1B divu: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = a, err=1, same WIDTH-cycle latency.
  - Signed overflow (most-negative / −1): lo = a, hi = 0, err=0.
- `ALU_DIV_EN` undefined: 0x1A and 0x1B are illegal (1 cycle, err=1). No divider logic is present.

## Test plan
- Reset, then add a=0x7FFFFFFF, b=1 → next cycle out_valid=1, result=0x80000000, zero=0, err=0.
- Back-to-back sub 5−5 then slt a=0xFFFFFFFF, b=1 → out_valid=1 in two consecutive cycles; results 0 (zero=1), then 1.
- mult a=0xFFFFFFFE (−2), b=3 → in_ready=0 for 32 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. An mfhi issued that same cycle returns 0xFFFFFFFF.
- multu a=b=0xFFFFFFFF; reset asserted at cycle 10 of MUL → no out_valid; hi=lo=0; in_ready=1 after reset.
- alu_op=11, then funct=0x3F → both complete with err=1, result=0; HI/LO unchanged.
- With ALU_DIV_EN: div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 9/0 → lo=0xFFFFFFFF, hi=9, err=1. Without the macro: div → 1-cycle err=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// EX-stage execute unit: ALUOp/funct decode, registered single-cycle ALU,
// iterative shift-add multiplier writing HI/LO and, when ALU_DIV_EN is
// defined, an iterative restoring divider writing HI/LO.
//
// Optional feature macro: ALU_DIV_EN (adds div/divu; otherwise they decode
// as illegal and no divider logic is built).
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : synchronous, active-high
//   in_valid   : operation request
//   in_ready   : unit idle, request is accepted on in_valid & in_ready
//   alu_op     : 00 add, 01 sub, 10 decode funct, 11 illegal
//   funct      : R-type function field
//   a, b       : operands, sampled only at acceptance
//   out_valid  : one-cycle completion pulse
//   result     : registered result (new LO for mult/div)
//   zero       : registered (result == 0)
//   err        : illegal op or divide by zero, valid with out_valid
//   hi, lo     : architectural HI/LO registers
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MULT  = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_ILL   = 4'd11;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
`endif

  // Magnitude of an operand; signed interpretation only when requested.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             vld_p1;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             err_p1;
  logic [WIDTH-1:0] hi_p1;
  logic [WIDTH-1:0] lo_p1;

  logic [3:0]       op_sel;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  logic             accept;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign a_s      = a;
  assign b_s      = b;

  // ---- stage p0: decode and single-cycle ALU ----
  always_comb begin
    op_sel = OP_ILL;
    case (alu_op)
      2'b00: op_sel = OP_ADD;
      2'b01: op_sel = OP_SUB;
      2'b10: begin
        case (funct)
          6'h20:   op_sel = OP_ADD;
          6'h22:   op_sel = OP_SUB;
          6'h24:   op_sel = OP_AND;
          6'h25:   op_sel = OP_OR;
          6'h27:   op_sel = OP_NOR;
          6'h2A:   op_sel = OP_SLT;
          6'h2B:   op_sel = OP_SLTU;
          6'h10:   op_sel = OP_MFHI;
          6'h12:   op_sel = OP_MFLO;
          6'h18:   op_sel = OP_MULT;
          6'h19:   op_sel = OP_MULTU;
`ifdef ALU_DIV_EN
          6'h1A:   op_sel = OP_DIV;
          6'h1B:   op_sel = OP_DIVU;
`endif
          default: op_sel = OP_ILL;
        endcase
      end
      default: op_sel = OP_ILL;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_sel)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: alu_res = hi_p1;
      OP_MFLO: alu_res = lo_p1;
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // ---- iterative multiplier datapath ----
  // acc holds {partial sum (WIDTH+1 bits), remaining multiplier bits};
  // each step conditionally adds the multiplicand and shifts right by one.
  logic [WIDTH-1:0]   mcand_p1;
  logic [2*WIDTH:0]   acc_p1;
  logic               mneg_p1;
  logic [WIDTH:0]     mul_upper;
  logic [2*WIDTH:0]   mul_next;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    mul_upper = acc_p1[2*WIDTH:WIDTH] + {1'b0, (acc_p1[0] ? mcand_p1 : {WIDTH{1'b0}})};
    mul_next  = {1'b0, mul_upper, acc_p1[WIDTH-1:1]};
    prod_fix  = cond_neg2(mul_next[2*WIDTH-1:0], mneg_p1);
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (in_valid) begin
        mcand_p1 <= mag(a, op_sel == OP_MULT);
        acc_p1   <= {{(WIDTH+1){1'b0}}, mag(b, op_sel == OP_MULT)};
        mneg_p1  <= (op_sel == OP_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
      end
    end else if (state == S_MUL) begin
      acc_p1 <= mul_next;
    end
  end

`ifdef ALU_DIV_EN
  // ---- iterative restoring divider datapath ----
  // quo starts as the dividend magnitude and is shifted out MSB-first into
  // rem while quotient bits are shifted in at the bottom.
  logic [WIDTH-1:0] dvsr_p1;
  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH-1:0] rem_p1;
  logic             negq_p1;
  logic             negr_p1;
  logic             dz_p1;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    rem_sh   = {rem_p1, quo_p1[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - dvsr_p1;
    div_ge   = (rem_sh >= {1'b0, dvsr_p1});
    rem_next = div_ge ? rem_diff : rem_sh[WIDTH-1:0];
    quo_next = {quo_p1[WIDTH-2:0], div_ge};
    // With a zero divisor every step subtracts nothing, so the remainder
    // path ends up holding the original dividend; only LO needs forcing.
    quo_fix  = dz_p1 ? {WIDTH{1'b1}} : cond_neg(quo_next, negq_p1);
    rem_fix  = cond_neg(rem_next, negr_p1);
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (in_valid) begin
        dvsr_p1 <= mag(b, op_sel == OP_DIV);
        quo_p1  <= mag(a, op_sel == OP_DIV);
        rem_p1  <= '0;
        negq_p1 <= (op_sel == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
        negr_p1 <= (op_sel == OP_DIV) && a[WIDTH-1];
        dz_p1   <= (b == '0);
      end
    end else if (state == S_DIV) begin
      quo_p1 <= quo_next;
      rem_p1 <= rem_next;
    end
  end
`endif

  // ---- stage p1: control, completion and architectural registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      err_p1    <= 1'b0;
      hi_p1     <= '0;
      lo_p1     <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_sel == OP_MULT || op_sel == OP_MULTU) begin
              state <= S_MUL;
              cnt   <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
            end else if (op_sel == OP_DIV || op_sel == OP_DIVU) begin
              state <= S_DIV;
              cnt   <= CNT_W'(WIDTH);
`endif
            end else begin
              vld_p1    <= 1'b1;
              result_p1 <= alu_res;
              zero_p1   <= (alu_res == '0);
              err_p1    <= alu_err;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt - CNT_W'(1);
          // Last iteration: commit the product straight from the step logic.
          if (cnt == CNT_W'(1)) begin
            state     <= S_IDLE;
            vld_p1    <= 1'b1;
            hi_p1     <= prod_fix[2*WIDTH-1:WIDTH];
            lo_p1     <= prod_fix[WIDTH-1:0];
            result_p1 <= prod_fix[WIDTH-1:0];
            zero_p1   <= (prod_fix[WIDTH-1:0] == '0);
            err_p1    <= 1'b0;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= S_IDLE;
            vld_p1    <= 1'b1;
            hi_p1     <= rem_fix;
            lo_p1     <= quo_fix;
            result_p1 <= quo_fix;
            zero_p1   <= (quo_fix == '0);
            err_p1    <= dz_p1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;
  assign zero      = zero_p1;
  assign err       = err_p1;
  assign hi        = hi_p1;
  assign lo        = lo_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed, table-driven bench for alu_exec_unit (WIDTH = 32): single-cycle
// vectors applied back-to-back from a struct table, plus hand sequences for
// multiply, mid-operation reset, illegal ops with HI/LO retention and, with
// ALU_DIV_EN, the divider corner cases.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          zero;
  logic          err;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .err       (err),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] va, input logic [31:0] vb);
    in_valid = v;
    alu_op   = op;
    funct    = fn;
    a        = va;
    b        = vb;
  endtask

  // Issue a multi-cycle op, check in_ready is low for exactly 32 cycles and
  // that the completion cycle carries the expected HI/LO/result/err.
  task automatic run_long(input string name, input logic [5:0] fn,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input logic ee);
    int busy_bad;
    busy_bad = 0;
    drive(1'b1, 2'b10, fn, va, vb);
    step();
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    for (int i = 0; i < W; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      step();
    end
    chk({name, " busy cycles"}, 32'(busy_bad), 32'd0);
    chk({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    chk({name, " result"}, result, el);
    chk({name, " zero"}, {31'd0, zero}, {31'd0, (el == 32'd0)});
    chk({name, " err"}, {31'd0, err}, {31'd0, ee});
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{"add op00",   2'b00, 6'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    vecs[1]  = '{"sub op01",   2'b01, 6'h00, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{"slt neg",    2'b10, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{"sltu big",   2'b10, 6'h2B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{"add wrap",   2'b10, 6'h20, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{"sub wrap",   2'b10, 6'h22, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6]  = '{"and",        2'b10, 6'h24, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0, 1'b0};
    vecs[7]  = '{"or",         2'b10, 6'h25, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[8]  = '{"nor",        2'b10, 6'h27, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h000F000F, 1'b0, 1'b0};
    vecs[9]  = '{"slt minint", 2'b10, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
    vecs[10] = '{"slt pos",    2'b10, 6'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{"mfhi reset", 2'b10, 6'h10, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{"ill op11",   2'b11, 6'h20, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b1};
    vecs[13] = '{"ill fn3F",   2'b10, 6'h3F, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b1};

    // Reset, with a request present that must be ignored.
    reset = 1'b1;
    drive(1'b1, 2'b00, 6'h00, 32'h1, 32'h1);
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    // Single-cycle vectors issued back-to-back, one per cycle.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].fn, vecs[i].va, vecs[i].vb);
      step();
      chk({vecs[i].name, " out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, " in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({vecs[i].name, " result"}, result, vecs[i].exp_res);
      chk({vecs[i].name, " zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      chk({vecs[i].name, " err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
    end
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    step();
    chk("idle out_valid", {31'd0, out_valid}, 32'd0);
    chk("table hi untouched", hi, 32'd0);
    chk("table lo untouched", lo, 32'd0);

    // Signed multiply, then mfhi/mflo in the completion cycle and after.
    run_long("mult -2*3", 6'h18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    drive(1'b1, 2'b10, 6'h10, 32'h0, 32'h0);
    step();
    chk("mfhi after mult out_valid", {31'd0, out_valid}, 32'd1);
    chk("mfhi after mult", result, 32'hFFFFFFFF);
    drive(1'b1, 2'b10, 6'h12, 32'h0, 32'h0);
    step();
    chk("mflo after mult", result, 32'hFFFFFFFA);
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    step();

    // Illegal ops must not disturb HI/LO.
    drive(1'b1, 2'b11, 6'h18, 32'h5, 32'h6);
    step();
    chk("ill op11 err", {31'd0, err}, 32'd1);
    chk("ill op11 result", result, 32'd0);
    drive(1'b1, 2'b10, 6'h3F, 32'h5, 32'h6);
    step();
    chk("ill fn3F out_valid", {31'd0, out_valid}, 32'd1);
    chk("ill fn3F err", {31'd0, err}, 32'd1);
    chk("ill fn3F result", result, 32'd0);
    chk("ill hi kept", hi, 32'hFFFFFFFF);
    chk("ill lo kept", lo, 32'hFFFFFFFA);
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    step();

    // Unsigned multiply and signed negative*negative.
    run_long("multu 2^16*2^16", 6'h19, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
    run_long("multu max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_long("mult -3*-5", 6'h18, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0);

`ifdef ALU_DIV_EN
    run_long("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_long("div 7/-2", 6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_long("divu 9/0", 6'h1B, 32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF, 1'b1);
    run_long("div ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_long("divu 100/7", 6'h1B, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0);
`else
    drive(1'b1, 2'b10, 6'h1A, 32'hFFFFFFF9, 32'h00000002);
    step();
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    chk("div nodiv out_valid", {31'd0, out_valid}, 32'd1);
    chk("div nodiv in_ready", {31'd0, in_ready}, 32'd1);
    chk("div nodiv err", {31'd0, err}, 32'd1);
    chk("div nodiv result", result, 32'd0);
    chk("div nodiv lo kept", lo, 32'h0000000F);
`endif

    // multu aborted by reset in cycle 10 of MUL.
    drive(1'b1, 2'b10, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    for (int i = 1; i < 10; i++) step();
    chk("abort busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid !== 1'b0) pulses++;
        step();
      end
      chk("abort no late out_valid", 32'(pulses), 32'd0);
    end
    chk("abort hi later", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
